// File: rtl/Stark_pkg.sv
// Stark_pkg: shared constants and the line FIFO entry type for the Stark fetch/extract path
package Stark_pkg;
  localparam int STARK_SLOTS = 16;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  typedef struct packed {
    logic [511:0] line;
    logic [31:0]  pc;
    logic [15:0]  cmask;
    logic [4:0]   ptr;
  } ex_line_entry_t;
endpackage

// File: rtl/stark_slot_select.sv
// stark_slot_select: picks the next NLANES eligible slots at/after ptr, plus the following eligible slot as next_ptr
//   ptr       in  5        first slot considered (16 = exhausted)
//   elig      in  16       slot eligibility mask
//   idx       out NLANESx4 selected slot per lane, low lanes first
//   vld       out NLANES   lane got a slot
//   next_ptr  out 5        first eligible slot after the last selected one, 16 if none
//   exhausted out 1        next_ptr == 16
module stark_slot_select
  import Stark_pkg::*;
#(
  parameter int NLANES = 4
) (
  input  logic [4:0]             ptr,
  input  logic [15:0]            elig,
  output logic [NLANES-1:0][3:0] idx,
  output logic [NLANES-1:0]      vld,
  output logic [4:0]             next_ptr,
  output logic                   exhausted
);
  always_comb begin
    logic [15:0] rem;
    rem = '0;
    idx = '0;
    vld = '0;
    next_ptr = 5'd16;
    for (int i = 0; i < STARK_SLOTS; i++) rem[i] = elig[i] && (5'(i) >= ptr);
    for (int l = 0; l < NLANES; l++) begin
      for (int i = STARK_SLOTS - 1; i >= 0; i--)
        if (rem[i]) begin
          idx[l] = 4'(i);
          vld[l] = 1'b1;
        end
      if (vld[l]) rem[idx[l]] = 1'b0;
    end
    for (int i = STARK_SLOTS - 1; i >= 0; i--)
      if (rem[i]) next_ptr = 5'(i);
    exhausted = next_ptr == 5'd16;
  end
endmodule

// File: rtl/stark_ins_extract.sv
// stark_ins_extract: buffers cache lines in a 2-entry FIFO and emits groups of up to NLANES instructions per cycle
//   clk, rst (sync, active-high), flush (drops all buffered and presented state)
//   line_v/line_rdy/line/line_pc/line_start/line_cmask : upstream cache line handshake
//   out_v/out_rdy/out_ins/out_pc/out_lane_v/out_nop/out_cline : registered instruction group to the decoders
//   STARK_EXTRACT_SKIP_CONST_EN: when defined, constant slots are skipped instead of presented as NOPs
module stark_ins_extract
  import Stark_pkg::*;
#(
  parameter int NLANES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 line_v,
  output logic                 line_rdy,
  input  logic [511:0]         line,
  input  logic [31:0]          line_pc,
  input  logic [3:0]           line_start,
  input  logic [15:0]          line_cmask,
  output logic                 out_v,
  input  logic                 out_rdy,
  output logic [NLANES*32-1:0] out_ins,
  output logic [NLANES*32-1:0] out_pc,
  output logic [NLANES-1:0]    out_lane_v,
  output logic [NLANES-1:0]    out_nop,
  output logic [511:0]         out_cline
);
  ex_line_entry_t q [2];
  ex_line_entry_t e;
  logic [1:0] count, cp;
  logic adv, wr, pop, hv, exh;
  logic [NLANES-1:0][3:0] idx;
  logic [NLANES-1:0] vld, nop_d;
  logic [4:0] nxt;
  logic [15:0] elig, nop_mask;
  logic [NLANES*32-1:0] ins_d, pc_d;
`ifdef STARK_EXTRACT_SKIP_CONST_EN
  assign elig = ~q[0].cmask;
  assign nop_mask = '0;
`else
  assign elig = '1;
  assign nop_mask = q[0].cmask;
`endif
  stark_slot_select #(.NLANES(NLANES)) u_sel (
    .ptr(q[0].ptr),
    .elig(elig),
    .idx(idx),
    .vld(vld),
    .next_ptr(nxt),
    .exhausted(exh)
  );
  assign e = '{line: line, pc: line_pc, cmask: line_cmask, ptr: {1'b0, line_start}};
  assign line_rdy = count != 2'd2 && !flush;
  assign wr = line_v && line_rdy;
  assign hv = count != 2'd0;
  assign adv = !out_v || out_rdy;
  // a head with no slot left (including an all-constant head) leaves the FIFO on this advance
  assign pop = adv && hv && exh;
  assign cp = count - {1'b0, pop};
  always_comb begin
    ins_d = '0;
    pc_d = '0;
    nop_d = '0;
    for (int l = 0; l < NLANES; l++)
      if (hv && vld[l]) begin
        nop_d[l] = nop_mask[idx[l]];
        pc_d[l*32 +: 32] = q[0].pc + {26'd0, idx[l], 2'b00};
        ins_d[l*32 +: 32] = nop_d[l] ? NOP_INSN : q[0].line[{idx[l], 5'd0} +: 32];
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      q <= '{default: '0};
      out_v <= 1'b0;
      out_ins <= '0;
      out_pc <= '0;
      out_lane_v <= '0;
      out_nop <= '0;
      out_cline <= '0;
    end else if (flush) begin
      count <= '0;
      out_v <= 1'b0;
      out_lane_v <= '0;
      out_nop <= '0;
    end else begin
      if (adv) begin
        out_v <= hv && vld[0];
        out_lane_v <= hv ? vld : '0;
        out_nop <= nop_d;
        out_ins <= ins_d;
        out_pc <= pc_d;
        out_cline <= q[0].line;
      end
      if (pop) q[0] <= q[1];
      else if (adv && hv) q[0].ptr <= nxt;
      // on a write+pop at count 1 this lands in entry 0 and overrides the shift
      if (wr) q[cp[0]] <= e;
      count <= cp + {1'b0, wr};
    end
  end
endmodule

// File: tb/tb_stark_ins_extract.sv
// tb_stark_ins_extract: randomized bench against a group-list reference model of the extractor
module tb_stark_ins_extract;
  import Stark_pkg::*;
  localparam int NL = 4;
`ifdef STARK_EXTRACT_SKIP_CONST_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  typedef struct packed {
    logic [NL-1:0]      lane_v;
    logic [NL-1:0]      nop;
    logic [NL*32-1:0]   ins;
    logic [NL*32-1:0]   pc;
  } group_t;
  typedef struct packed {
    group_t [15:0] g;
    logic [4:0]    n;
    logic [4:0]    gi;
    logic [511:0]  line;
  } rec_t;
  typedef struct {
    int cyc;
    int pv;
    int pr;
    int pf;
    int cmode;
  } phase_t;

  logic clk = 0, rst = 1, flush = 0, line_v = 0, out_rdy = 0;
  logic line_rdy, out_v;
  logic [511:0] line = '0, out_cline;
  logic [31:0] line_pc = '0;
  logic [3:0] line_start = '0;
  logic [15:0] line_cmask = '0;
  logic [NL*32-1:0] out_ins, out_pc;
  logic [NL-1:0] out_lane_v, out_nop;

  int n_chk = 0, n_pass = 0;
  rec_t fq[$];
  group_t m_g = '0;
  logic [511:0] m_cl = '0;
  bit m_v = 0;

  stark_ins_extract #(.NLANES(NL)) dut (
    .clk(clk), .rst(rst), .flush(flush), .line_v(line_v), .line_rdy(line_rdy),
    .line(line), .line_pc(line_pc), .line_start(line_start), .line_cmask(line_cmask),
    .out_v(out_v), .out_rdy(out_rdy), .out_ins(out_ins), .out_pc(out_pc),
    .out_lane_v(out_lane_v), .out_nop(out_nop), .out_cline(out_cline)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic rec_t mk(input logic [511:0] ln, input logic [31:0] pc, input logic [3:0] st,
                              input logic [15:0] cm);
    rec_t r;
    int k, gi, li;
    r = '0;
    r.line = ln;
    k = 0;
    for (int s = int'(st); s < 16; s++) begin
      if (!(SKIP && cm[s])) begin
        gi = k / NL;
        li = k % NL;
        r.g[gi].lane_v[li] = 1'b1;
        r.g[gi].nop[li] = cm[s];
        r.g[gi].ins[li*32 +: 32] = cm[s] ? NOP_INSN : ln[s*32 +: 32];
        r.g[gi].pc[li*32 +: 32] = pc + 32'(4 * s);
        k++;
      end
    end
    r.n = 5'((k + NL - 1) / NL);
    return r;
  endfunction

  phase_t ph[6] = '{
    '{40, 100, 100, 0, 0},
    '{80, 70, 60, 3, 1},
    '{40, 100, 0, 0, 1},
    '{80, 90, 30, 0, 2},
    '{60, 50, 100, 5, 1},
    '{120, 60, 70, 4, 2}
  };

  initial begin
    bit m_rdy;
    rec_t r;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    check("reset_out_v", out_v, 0);
    check("reset_lane_v", out_lane_v, 0);
    check("reset_nop", out_nop, 0);
    check("reset_ins", out_ins, 0);
    check("reset_pc", out_pc, 0);
    check("reset_cline", out_cline, 0);
    check("reset_line_rdy", line_rdy, 1);
    foreach (ph[p]) begin
      for (int c = 0; c < ph[p].cyc; c++) begin
        @(negedge clk);
        check("out_v", out_v, m_v);
        if (m_v && out_v) begin
          check("lane_v", out_lane_v, m_g.lane_v);
          check("nop", out_nop, m_g.nop);
          check("ins", out_ins, m_g.ins);
          check("pc", out_pc, m_g.pc);
          check("cline", out_cline, m_cl);
        end
        flush = $urandom_range(99) < ph[p].pf;
        line_v = $urandom_range(99) < ph[p].pv;
        out_rdy = $urandom_range(99) < ph[p].pr;
        for (int w = 0; w < 16; w++) line[w*32 +: 32] = $urandom;
        line_pc = $urandom & 32'hFFFF_FFC0;
        case (ph[p].cmode)
          0: begin line_cmask = '0; line_start = '0; end
          1: begin line_cmask = 16'($urandom) & 16'($urandom); line_start = 4'($urandom); end
          default: begin
            line_cmask = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom) | 16'($urandom);
            line_start = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15, 12));
          end
        endcase
        #1;
        m_rdy = fq.size() != 2 && !flush;
        check("line_rdy", line_rdy, m_rdy);
        if (flush) begin
          fq.delete();
          m_v = 0;
        end else begin
          if (!m_v || out_rdy) begin
            if (fq.size() == 0) m_v = 0;
            else begin
              r = fq[0];
              if (r.n == 0) begin
                m_v = 0;
                void'(fq.pop_front());
              end else begin
                m_g = r.g[r.gi];
                m_cl = r.line;
                m_v = 1;
                r.gi++;
                if (r.gi == r.n) void'(fq.pop_front());
                else fq[0] = r;
              end
            end
          end
          if (line_v && m_rdy) fq.push_back(mk(line, line_pc, line_start, line_cmask));
        end
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/stark_ins_extract.md
# stark_ins_extract

Fetch-side instruction extractor for the Stark core. It sits between the I-cache line output and the bank of `Stark_decoder` instances. It buffers 512-bit cache lines and slices each into 32-bit instruction slots, skipping slots that hold instruction constants. Each cycle it presents up to NLANES instructions from a single line, together with that line, so the decoders can fetch their constants from it.

## Interface
Parameters:
- NLANES, 4, instructions presented per output group (1..4)

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  branch/exception redirect; discard all buffered and presented state
- line_v  in  1  upstream line valid
- line_rdy  out  1  block can accept a line this cycle
- line  in  512  cache line; 16 slots of 32 bits, slot 0 in [31:0]
- line_pc  in  32  byte address of slot 0 (64-byte aligned)
- line_start  in  4  first slot to execute (branch target offset)
- line_cmask  in  16  predecoded mask; bit i set means slot i is a constant
- out_v  out  1  output group valid
- out_rdy  in  1  decode stage accepts group
- out_ins  out  NLANES×32  instruction per lane
- out_pc  out  NLANES×32  PC per lane (line_pc + 4×slot)
- out_lane_v  out  NLANES  lane holds a real instruction
- out_nop  out  NLANES  lane is a constant slot forced to NOP (only without skip feature)
- out_cline  out  512  line the group was drawn from

## Operation
- Two-entry line FIFO (count 0..2). Each entry holds line, pc, cmask and a 5-bit slot pointer `ptr` (value 16 = exhausted). `ptr` loads from line_start on write.
- line_rdy = (count != 2) & ~flush. A write occurs on line_v & line_rdy.
- Output register advances when ~out_v | out_rdy. On advance with count ≥ 1, select up to NLANES eligible slots from the head at or after `ptr`, in ascending order.
  - Lanes are filled low-first. Unused lanes have out_lane_v = 0 and out_ins = 0.
- After selection, head `ptr` becomes one past the last selected slot, then skips any following constant slots.
- If the resulting `ptr` reaches 16, the head pops in the same cycle. The next group then comes from the next line.
- A group never spans two lines.
- A head with no eligible slot at or after `ptr` (all constants) pops without producing a group: out_v is 0 that cycle.
- On advance with count = 0, or with no eligible slot, out_v is cleared.
- Simultaneous write and pop on a full FIFO is not possible, because line_rdy is 0 when count = 2.
  - A write and pop on count = 1 leaves count = 1, with the new line at the head.
- flush has priority over everything. It sets count = 0 and out_v = 0, and discards any line_v that cycle.
- Reset values: out_v 0, out_lane_v 0, out_nop 0, out_ins/out_pc/out_cline 0, count 0, line_rdy 1 once rst is low.
- Arithmetic: out_pc = line_pc + {slot, 2'b00}, modulo 2^32. Slot indices are 4-bit with no wrap beyond slot 15.

## Timing
- Line written at edge k. Its first group can appear (out_v = 1) after edge k+1.
- Steady state: one group per cycle while out_rdy = 1.
- out_rdy = 0 holds all out_* stable; `ptr` and the FIFO do not advance.
- flush at edge k: out_v = 0 after k. A line offered in cycle k+1 yields out_v after edge k+2.
- All outputs are registered except line_rdy, which is combinational from count and flush.

## Configuration
- STARK_EXTRACT_SKIP_CONST_EN defined: constant slots are ineligible and are never placed in a lane. out_nop is tied to 0.
- Not defined: every slot from `ptr` onward is eligible. Constant slots occupy a lane with out_lane_v = 1, out_nop = 1 and out_ins = the NOP encoding from Stark_pkg. This mode is for decoders that mark constant positions themselves.

## Structure
- Stark_pkg holds `NOP_INSN`, the `Stark_pkg::ex_line_entry_t` struct (line, pc, cmask, ptr) and `STARK_SLOTS = 16`.
- One sub-module, `stark_slot_select`: combinational pick of the next NLANES eligible slot indices from ptr and the eligibility mask. It also returns the next ptr and an exhausted flag.

## Test plan
- Lane fill: line_start 0, cmask 0, NLANES 4, out_rdy held 1 -> four groups of slots 0-3, 4-7, 8-11, 12-15. Line pops on the fourth group.
- Constant skip (macro defined): cmask 0x0006, start 0 -> group 1 is slots 0, 3, 4, 5 with out_pc 0x…00, …0C, …10, …14.
- Constants in lanes (macro undefined): cmask 0x0006, start 0 -> group 1 is slots 0-3, with out_nop = 4'b0110 on lanes 1 and 2.
- Mid-line start and partial group: line_start 14 -> one group with lanes 0-1 valid (slots 14, 15) and out_lane_v = 4'b0011. The next line follows on the next cycle.
- Backpressure: out_rdy low for 5 cycles while two lines arrive -> outputs stable, line_rdy = 0 at count 2. No slot is lost or duplicated after release.
- Flush: flush asserted while out_v = 1, count = 2 and line_v = 1 -> out_v = 0 next cycle, count 0, offered line dropped. A new line's slot line_start appears after two edges.
